// File: rtl/priority_drain_encoder_pkg.sv
// Shared constants for the priority drain encoder: FSM state encoding and N limits.
package penc_pkg;

   localparam int STATE_W = 2;
   localparam int N_MIN   = 2;
   localparam int N_MAX   = 64;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      EMPTY = 2'd2
   } state_t;

endpackage

// File: rtl/priority_drain_encoder_if.sv
// Request-in / index-out handshake bundle. out_last exists only with PENC_LAST_EN defined.
interface priority_drain_encoder_if #(
   parameter int N = 8
);
   localparam int W = $clog2(N);

   logic         in_valid;
   logic [N-1:0] in_req;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_none;
`ifdef PENC_LAST_EN
   logic         out_last;
`endif

   // master: the environment offering vectors and consuming beats
   modport master (
      output in_valid, in_req, out_ready,
      input  in_ready, out_valid, out_idx, out_none
`ifdef PENC_LAST_EN
      , input out_last
`endif
   );

   // slave: the encoder itself
   modport slave (
      input  in_valid, in_req, out_ready,
      output in_ready, out_valid, out_idx, out_none
`ifdef PENC_LAST_EN
      , output out_last
`endif
   );

endinterface

// File: rtl/priority_drain_encoder_find.sv
// Combinational priority pick over a vector: returns index and one-hot of the winning bit.
module penc_find #(
   parameter int  N         = 8,
   parameter bit  MSB_FIRST = 1'b1,
   localparam int W         = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot
);

   // Later hits overwrite earlier ones, so scan direction sets the priority.
   always_comb begin
      idx    = '0;
      onehot = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
               idx       = W'(i);
               onehot    = '0;
               onehot[i] = 1'b1;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
               idx       = W'(i);
               onehot    = '0;
               onehot[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/priority_drain_encoder.sv
// Registered priority drain encoder: captures a request vector, emits one index per output beat.
// Optional out_last beat marker is built when PENC_LAST_EN is defined.
module priority_drain_encoder
   import penc_pkg::*;
#(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                      clk,
   input logic                      rst,
   priority_drain_encoder_if.slave  bus
);

   localparam int W = $clog2(N);

   state_t       state, state_nx;
   logic [N-1:0] pending, pending_nx;
   logic [N-1:0] pick;
   logic [W-1:0] pick_idx;
   logic         hs_in, hs_out;
   logic         final_beat;

   penc_find #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_find (
      .vec    (pending),
      .idx    (pick_idx),
      .onehot (pick)
   );

   assign hs_in  = bus.in_valid  & bus.in_ready;
   assign hs_out = bus.out_valid & bus.out_ready;

   // The current beat is final when only the picked bit is left (or the vector was empty).
   assign final_beat = (state == EMPTY) || ((state == DRAIN) && (pending == pick));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         state   <= state_nx;
         pending <= pending_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      pending_nx = pending;
      case (state)
         IDLE: begin
            if (hs_in) begin
               if (|bus.in_req) begin
                  pending_nx = bus.in_req;
                  state_nx   = DRAIN;
               end else begin
                  state_nx   = EMPTY;
               end
            end
         end
         DRAIN: begin
            if (hs_out) begin
               pending_nx = pending & ~pick;
               if (final_beat) state_nx = IDLE;
            end
         end
         EMPTY: begin
            if (hs_out) state_nx = IDLE;
         end
         default: begin
            state_nx   = IDLE;
            pending_nx = '0;
         end
      endcase
   end

   // in_ready is masked by rst so it stays low for the whole reset window.
   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == DRAIN) || (state == EMPTY);
   assign bus.out_idx   = (state == DRAIN) ? pick_idx : '0;
   assign bus.out_none  = (state == EMPTY);
`ifdef PENC_LAST_EN
   assign bus.out_last  = final_beat;
`endif

endmodule

// File: tb/tb_priority_drain_encoder.sv
// Directed bench for priority_drain_encoder: N=8 MSB-first, N=8 LSB-first and N=5 MSB-first instances.
module tb_priority_drain_encoder;
   import penc_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   priority_drain_encoder_if #(.N(8)) ba ();
   priority_drain_encoder_if #(.N(8)) bb ();
   priority_drain_encoder_if #(.N(5)) bc ();

   priority_drain_encoder #(.N(8), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ba));
   priority_drain_encoder #(.N(8), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bb));
   priority_drain_encoder #(.N(5), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   // Check one beat on instance A, then advance one cycle.
   task automatic a_beat(input string tag, input int idx, input bit none, input bit last);
      chk({tag, "_valid"}, 64'(ba.out_valid), 64'd1);
      chk({tag, "_idx"},   64'(ba.out_idx),   64'(idx));
      chk({tag, "_none"},  64'(ba.out_none),  64'(none));
      chk({tag, "_rdy"},   64'(ba.in_ready),  64'd0);
`ifdef PENC_LAST_EN
      chk({tag, "_last"},  64'(ba.out_last),  64'(last));
`else
      if (last) begin end
`endif
      nxt();
   endtask

   task automatic a_send(input logic [7:0] req);
      ba.in_valid = 1'b1;
      ba.in_req   = req;
      nxt();
      ba.in_valid = 1'b0;
      ba.in_req   = 8'h5A;
   endtask

   task automatic a_idle(input string tag);
      chk({tag, "_valid"}, 64'(ba.out_valid), 64'd0);
      chk({tag, "_rdy"},   64'(ba.in_ready),  64'd1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      ba.in_valid = 1'b0; ba.in_req = '0; ba.out_ready = 1'b0;
      bb.in_valid = 1'b0; bb.in_req = '0; bb.out_ready = 1'b0;
      bc.in_valid = 1'b0; bc.in_req = '0; bc.out_ready = 1'b0;

      // Reset state
      nxt(); nxt();
      chk("rst_rdy",   64'(ba.in_ready),  64'd0);
      chk("rst_valid", 64'(ba.out_valid), 64'd0);
      chk("rst_idx",   64'(ba.out_idx),   64'd0);
      chk("rst_none",  64'(ba.out_none),  64'd0);
`ifdef PENC_LAST_EN
      chk("rst_last",  64'(ba.out_last),  64'd0);
`endif
      rst = 1'b0;
      nxt();
      a_idle("post_rst");

      // 1: basic drain, 7,5,2 on consecutive cycles
      ba.out_ready = 1'b1;
      a_send(8'b1010_0100);
      a_beat("t1_b0", 7, 1'b0, 1'b0);
      a_beat("t1_b1", 5, 1'b0, 1'b0);
      a_beat("t1_b2", 2, 1'b0, 1'b1);
      a_idle("t1_end");

      // 2: zero vector -> single none beat
      a_send(8'h00);
      a_beat("t2_b0", 0, 1'b1, 1'b1);
      a_idle("t2_end");

      // 3: backpressure holds idx 5, then 5 and 0
      ba.out_ready = 1'b0;
      a_send(8'b0010_0001);
      a_beat("t3_h0", 5, 1'b0, 1'b0);
      a_beat("t3_h1", 5, 1'b0, 1'b0);
      a_beat("t3_h2", 5, 1'b0, 1'b0);
      ba.out_ready = 1'b1;
      a_beat("t3_b0", 5, 1'b0, 1'b0);
      a_beat("t3_b1", 0, 1'b0, 1'b1);
      a_idle("t3_end");

      // 4: reset mid-drain drops out_valid asynchronously
      a_send(8'hFF);
      a_beat("t4_b0", 7, 1'b0, 1'b0);
      a_beat("t4_b1", 6, 1'b0, 1'b0);
      chk("t4_pre_idx", 64'(ba.out_idx), 64'd5);
      #2 rst = 1'b1;
      #1;
      chk("t4_rst_valid", 64'(ba.out_valid), 64'd0);
      chk("t4_rst_rdy",   64'(ba.in_ready),  64'd0);
      nxt();
      rst = 1'b0;
      #1;
      a_idle("t4_rel");
      nxt();
      a_send(8'h10);
      a_beat("t4_single", 4, 1'b0, 1'b1);
      a_idle("t4_end");
      ba.out_ready = 1'b0;

      // 5a: LSB-first order 2,5,7
      bb.out_ready = 1'b1;
      bb.in_valid  = 1'b1;
      bb.in_req    = 8'b1010_0100;
      nxt();
      bb.in_valid  = 1'b0;
      chk("t5b_idx0", 64'(bb.out_idx), 64'd2);
      nxt();
      chk("t5b_idx1", 64'(bb.out_idx), 64'd5);
      nxt();
      chk("t5b_idx2",   64'(bb.out_idx),   64'd7);
      chk("t5b_valid2", 64'(bb.out_valid), 64'd1);
      nxt();
      chk("t5b_end_valid", 64'(bb.out_valid), 64'd0);
      chk("t5b_end_rdy",   64'(bb.in_ready),  64'd1);

      // 5b: N=5, 4 then 0
      bc.out_ready = 1'b1;
      bc.in_valid  = 1'b1;
      bc.in_req    = 5'b10001;
      nxt();
      bc.in_valid  = 1'b0;
      chk("t5c_idx0", 64'(bc.out_idx), 64'd4);
      nxt();
      chk("t5c_idx1", 64'(bc.out_idx), 64'd0);
      nxt();
      chk("t5c_end_valid", 64'(bc.out_valid), 64'd0);

      // All-ones on N=5: exactly five beats 4..0
      bc.in_valid = 1'b1;
      bc.in_req   = 5'b11111;
      nxt();
      bc.in_valid = 1'b0;
      for (int k = 4; k >= 0; k--) begin
         chk("t5c_ones_valid", 64'(bc.out_valid), 64'd1);
         chk("t5c_ones_idx",   64'(bc.out_idx),   64'(k));
         nxt();
      end
      chk("t5c_ones_end", 64'(bc.out_valid), 64'd0);
      chk("t5c_ones_rdy", 64'(bc.in_ready),  64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
